// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART frame constants, FSM state encoding, timing helpers.
//  Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam bit LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

    function automatic int calc_half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : 1-bit two-flop synchroniser for asynchronous pins.
//  Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver with valid/ready output, framing/overrun pulses.
//  Revision : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 27000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE),
    parameter int HALF_BIT     = calc_half_bit(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_BITS - 1);

    logic                 w_rxd_s;
    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [IDX_W-1:0]     w_shift_pos;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_deliver;
    logic                 w_bit_done;
    logic                 w_stop_good;
    logic                 w_stop_bad;
    logic                 w_cnt_clr;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxd_s)
    );

    always_comb begin
        w_state_next = r_state;
        w_bit_done   = 1'b0;
        w_stop_good  = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxd_s) w_state_next = ST_START;
            end
            ST_START: begin
                if (r_cnt == c_cnt_half) w_state_next = w_rxd_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (r_cnt == c_cnt_last) begin
                    w_bit_done = 1'b1;
                    if (r_bit_idx == c_idx_last) w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == c_cnt_last) begin
                    if (w_rxd_s) begin
                        w_stop_good  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rxd_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The counter restarts on each state change and after every data-bit sample,
    // so each data bit is timed from the previous bit's mid-point.
    assign w_cnt_clr   = (w_state_next != r_state) || w_bit_done;
    assign w_shift_pos = LSB_FIRST ? r_bit_idx : (c_idx_last - r_bit_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_deliver <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_bit_done) begin
                r_shift[w_shift_pos] <= w_rxd_s;
                r_bit_idx            <= (r_bit_idx == c_idx_last) ? '0 : r_bit_idx + 1'b1;
            end
            r_deliver <= w_stop_good;
        end
    end

    // A same-cycle accept frees the buffer, so the new byte can land without overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_stop_bad;
            overrun   <= 1'b0;
            if (r_deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else begin
                if (r_deliver) overrun <= 1'b1;
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx: vector table plus corner sequences.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT = 27000000 / 115200;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         acc_cnt   = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         rise_cnt  = 0;
    int         hi_cnt    = 0;
    int         both_cnt  = 0;
    int         rise_cyc  = 0;
    logic [7:0] last_acc  = 8'h00;
    logic       v_prev    = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            acc_cnt++;
            last_acc = rx_data;
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid && !v_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (rx_valid) hi_cnt++;
        v_prev = rx_valid;
    end

    int n_total = 0;
    int n_pass  = 0;
    int t_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        idle(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_acc;
        int         exp_fe;
    } vec_t;

    vec_t vecs[8];

    int s_acc, s_fe, s_ov, s_rise, s_hi;

    task automatic snap();
        s_acc  = acc_cnt;
        s_fe   = fe_cnt;
        s_ov   = ov_cnt;
        s_rise = rise_cnt;
        s_hi   = hi_cnt;
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0};
        vecs[2] = '{8'h5A, 1'b1, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 0};
        vecs[5] = '{8'hFF, 1'b0, 0, 1};
        vecs[6] = '{8'h3C, 1'b1, 1, 0};
        vecs[7] = '{8'hC3, 1'b1, 1, 0};

        rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
        idle(5);
        rst = 1'b0;
        idle(1);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);

        snap();
        idle(1000);
        check("idle rx_valid", 32'(rx_valid), 32'd0);
        check("idle state", 32'(dut.r_state), 32'(ST_IDLE));
        check("idle fe", 32'(fe_cnt - s_fe), 32'd0);
        check("idle ov", 32'(ov_cnt - s_ov), 32'd0);

        // A5 with latency: 2 sync + 1 idle->start + 117 + 8*234 + 234 + 1 delivery = 2227
        rx_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        idle(BIT);
        check("A5 accepted", 32'(acc_cnt - s_acc), 32'd1);
        check("A5 data", 32'(last_acc), 32'hA5);
        check("A5 latency", 32'(rise_cyc - t_start), 32'd2227);
        check("A5 valid width", 32'(hi_cnt - s_hi), 32'd1);
        check("A5 fe", 32'(fe_cnt - s_fe), 32'd0);
        check("A5 ov", 32'(ov_cnt - s_ov), 32'd0);

        for (int v = 0; v < 8; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].stop);
            rxd = 1'b1;
            idle(BIT);
            check($sformatf("vec%0d accepted", v), 32'(acc_cnt - s_acc), 32'(vecs[v].exp_acc));
            check($sformatf("vec%0d fe", v), 32'(fe_cnt - s_fe), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d ov", v), 32'(ov_cnt - s_ov), 32'd0);
            if (vecs[v].exp_acc == 1) check($sformatf("vec%0d data", v), 32'(last_acc), 32'(vecs[v].data));
        end

        // Overrun: second byte dropped while the first is still held
        rx_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1);
        idle(BIT);
        send_frame(8'hC3, 1'b1);
        idle(BIT);
        check("ovr valid held", 32'(rx_valid), 32'd1);
        check("ovr data held", 32'(rx_data), 32'h3C);
        check("ovr pulses", 32'(ov_cnt - s_ov), 32'd1);
        check("ovr rises", 32'(rise_cnt - s_rise), 32'd1);
        check("ovr fe", 32'(fe_cnt - s_fe), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr valid in accept cycle", 32'(rx_valid), 32'd1);
        @(posedge clk); #1;
        check("ovr valid after accept", 32'(rx_valid), 32'd0);
        check("ovr accepted data", 32'(last_acc), 32'h3C);
        check("ovr accepted count", 32'(acc_cnt - s_acc), 32'd1);

        // Framing error followed by a held-low line
        snap();
        send_frame(8'hFF, 1'b0);
        idle(5 * BIT);
        check("brk state", 32'(dut.r_state), 32'(ST_BREAK));
        rxd = 1'b1;
        idle(BIT);
        check("brk fe once", 32'(fe_cnt - s_fe), 32'd1);
        check("brk no valid", 32'(rise_cnt - s_rise), 32'd0);
        snap();
        send_frame(8'h55, 1'b1);
        idle(BIT);
        check("post-brk accepted", 32'(acc_cnt - s_acc), 32'd1);
        check("post-brk data", 32'(last_acc), 32'h55);

        // Short glitch must not start a frame
        snap();
        rxd = 1'b0;
        idle(50);
        rxd = 1'b1;
        idle(500);
        check("glitch no valid", 32'(rise_cnt - s_rise), 32'd0);
        check("glitch fe", 32'(fe_cnt - s_fe), 32'd0);
        check("glitch state", 32'(dut.r_state), 32'(ST_IDLE));
        send_frame(8'h0F, 1'b1);
        idle(BIT);
        check("post-glitch accepted", 32'(acc_cnt - s_acc), 32'd1);
        check("post-glitch data", 32'(last_acc), 32'h0F);

        // Reset in the middle of bit 4 of 8'h81
        snap();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rxd = 1'b0;
        idle(BIT / 2);
        rst = 1'b1;
        rxd = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2 * BIT);
        check("rst state", 32'(dut.r_state), 32'(ST_IDLE));
        check("rst no valid", 32'(rise_cnt - s_rise), 32'd0);
        send_frame(8'h7E, 1'b1);
        idle(BIT);
        check("rst accepted", 32'(acc_cnt - s_acc), 32'd1);
        check("rst data", 32'(last_acc), 32'h7E);
        check("rst fe", 32'(fe_cnt - s_fe), 32'd0);
        check("rst ov", 32'(ov_cnt - s_ov), 32'd0);

        check("fe/ov never together", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
